// File: rtl/fb_window_scanner.sv
// Raster-order window scanner over the 640x480 frame buffer: streams tagged pixels or folds them into a checksum.
// Read-to-pixel latency 2 cycles; reads are credit-limited by a 2-entry output FIFO, so pix_ready stalls throttle the reads.
module fb_window_scanner #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int PIXEL_W   = 4,
    parameter int COORD_W   = 10,
    parameter int ADDR_W    = 19,
    parameter int CSUM_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [COORD_W-1:0] x_start,
    input  logic [COORD_W-1:0] y_start,
    input  logic [COORD_W-1:0] x_end,
    input  logic [COORD_W-1:0] y_end,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [PIXEL_W-1:0] mem_rd_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIXEL_W-1:0] pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_eol,
    output logic               pix_last,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CSUM_W-1:0]  checksum
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic [PIXEL_W-1:0] dat;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               eol;
        logic               last;
    } pix_ent_t;

    localparam logic [COORD_W-1:0] FB_W_C = COORD_W'(FB_WIDTH);
    localparam logic [COORD_W-1:0] FB_H_C = COORD_W'(FB_HEIGHT);
    localparam logic [ADDR_W-1:0]  PITCH  = ADDR_W'(FB_WIDTH);

    state_t             state_q;
    logic               mode_q;
    logic [COORD_W-1:0] xs_q, xe_q, ye_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic [ADDR_W-1:0]  row_base_q;
    logic               infl_vld_q, infl_eol_q, infl_last_q;
    logic [COORD_W-1:0] infl_x_q, infl_y_q;
    logic [CSUM_W-1:0]  csum_q;
    logic               busy_q, done_q, err_q;

    pix_ent_t           fifo_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         cnt_q;

    logic               win_bad, at_eol, at_last;
    logic               push, pop, issue, drain_empty;
    logic [2:0]         occ_after_pop, occ_next;
    pix_ent_t           push_ent, head;

    assign win_bad = (x_end <= x_start) || (y_end <= y_start) ||
                     (x_end > FB_W_C)   || (y_end > FB_H_C);
    assign at_eol  = (x_q == xe_q - COORD_W'(1));
    assign at_last = at_eol && (y_q == ye_q - COORD_W'(1));

    assign head      = fifo_q[rd_ptr_q];
    assign pix_valid = (cnt_q != 2'd0);
    assign pop       = pix_valid && pix_ready;
    assign push      = infl_vld_q && !mode_q;
    assign push_ent  = {mem_rd_data, infl_x_q, infl_y_q, infl_eol_q, infl_last_q};

    // The in-flight read counts against the FIFO, so returning data always has a slot.
    assign occ_after_pop = {1'b0, cnt_q} + {2'b00, infl_vld_q} - {2'b00, pop};
    assign occ_next      = {1'b0, cnt_q} + {2'b00, push} - {2'b00, pop};
    assign issue         = (state_q == SCAN) && (occ_after_pop < 3'd2);
    assign drain_empty   = (occ_next == 3'd0);

    assign mem_rd_en = issue;
    assign mem_addr  = row_base_q + ADDR_W'(x_q);
    assign pix_data  = head.dat;
    assign pix_x     = head.x;
    assign pix_y     = head.y;
    assign pix_eol   = head.eol;
    assign pix_last  = head.last;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign checksum  = csum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_ent;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= occ_next[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            xs_q        <= '0;
            xe_q        <= '0;
            ye_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
            infl_vld_q  <= 1'b0;
            infl_x_q    <= '0;
            infl_y_q    <= '0;
            infl_eol_q  <= 1'b0;
            infl_last_q <= 1'b0;
            csum_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            infl_vld_q  <= issue;
            infl_x_q    <= x_q;
            infl_y_q    <= y_q;
            infl_eol_q  <= at_eol;
            infl_last_q <= at_last;
            if (infl_vld_q && mode_q) begin
                csum_q <= csum_q + CSUM_W'(mem_rd_data);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        xs_q       <= x_start;
                        xe_q       <= x_end;
                        ye_q       <= y_end;
                        x_q        <= x_start;
                        y_q        <= y_start;
                        row_base_q <= ADDR_W'(y_start) * PITCH;
                        csum_q     <= '0;
                        busy_q     <= 1'b1;
                        if (win_bad) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (at_eol) begin
                            x_q        <= xs_q;
                            y_q        <= y_q + COORD_W'(1);
                            row_base_q <= row_base_q + PITCH;
                            if (at_last) begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            x_q <= x_q + COORD_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/fb_window_scanner.md
# fb_window_scanner

Hardware window scanner for the 640x480 frame buffer that the drawing pipeline writes. It walks a rectangular region in raster order through a synchronous read port, and does one of two things with the pixels:
- streams them out on a valid/ready interface with coordinates and row markers, or
- folds them into a checksum, so benches and the CPU can verify rendered shapes without dumping memory.

It sits beside the frame buffer's write side as a second read client.

## Interface
- FB_WIDTH, 640, frame buffer width in pixels (row pitch)
- FB_HEIGHT, 480, frame buffer height
- PIXEL_W, 4, bits per pixel
- COORD_W, 10, coordinate width
- ADDR_W, 19, frame buffer address width
- CSUM_W, 32, checksum width
- clk  in  1  system clock; one clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin scan; sampled only in IDLE
- mode  in  1  0 = stream, 1 = checksum; captured with start
- x_start, y_start  in  COORD_W  inclusive window origin
- x_end, y_end  in  COORD_W  exclusive window bounds
- mem_rd_en  out  1  frame buffer read strobe
- mem_addr  out  ADDR_W  y*FB_WIDTH + x
- mem_rd_data  in  PIXEL_W  read data, valid exactly 1 cycle after mem_rd_en
- pix_valid, pix_ready  out/in  1  output handshake
- pix_data  out  PIXEL_W  pixel value
- pix_x, pix_y  out  COORD_W  pixel coordinates
- pix_eol  out  1  last pixel of a row
- pix_last  out  1  last pixel of the window
- busy  out  1  scan in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for an invalid window
- checksum  out  CSUM_W  sum of all scanned pixels mod 2^CSUM_W; held until next start

## Operation
- States: IDLE, SCAN, DRAIN, FINISH.
- **IDLE**
  - On start, window and mode are registered.
  - The window is invalid if x_end<=x_start, y_end<=y_start, x_end>FB_WIDTH or y_end>FB_HEIGHT.
  - Invalid window: go to FINISH with err set, no reads issued, checksum cleared to 0.
  - Valid window: checksum cleared, go to SCAN.
- **SCAN: address generation**
  - row_base starts at y_start*FB_WIDTH and is incremented by FB_WIDTH per row (no per-pixel multiply).
  - x counts x_start..x_end-1, then x wraps to x_start and y increments.
  - After the read of (x_end-1, y_end-1) is issued, go to DRAIN.
- **SCAN: read credit**
  - Output FIFO depth is 2.
  - A read is issued only when occupancy + in-flight reads - (pop this cycle) < 2.
  - Data returned from the frame buffer is therefore never dropped.
- **Stream mode**
  - Each returned pixel is pushed with its x, y, eol and last tags.
  - The FIFO head drives the pix_* outputs.
  - A pop occurs when pix_valid && pix_ready.
- **Checksum mode**
  - Reads issue every cycle; pix_valid stays 0.
  - Each mem_rd_data is added to checksum the cycle after its read.
- **DRAIN**
  - Wait for in-flight reads to land and, in stream mode, for the FIFO to empty.
  - Then go to FINISH.
- **FINISH**
  - done=1 (and err if set) for one cycle.
  - Return to IDLE.
- start while not in IDLE is ignored.
- A change of mode mid-scan has no effect.
- rst_n low at any time, including mid-scan:
  - next state IDLE, FIFO flushed.
  - In-flight read data is discarded.
  - All outputs 0, including checksum.

## Timing
- Reset values: mem_rd_en, mem_addr, pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_last, busy, done, err, checksum all 0.
- Valid window, start sampled at edge 0:
  - busy high from cycle 1 through the done cycle inclusive.
  - First mem_rd_en in cycle 1.
  - First data at mem_rd_data in cycle 2.
  - First pix_valid in cycle 3.
- With pix_ready held high, stream mode sustains one pixel per cycle.
- N-pixel window, stream mode, ready=1: done is in cycle N+3.
- Checksum mode: done is in cycle N+2, and checksum is final in that cycle.
- Invalid window: done=err=1 in cycle 1, busy=1 in cycle 1 only.
- pix_* are stable while pix_valid && !pix_ready.

## Test plan
- Window (0,0)-(3,2), stream mode, ready=1, mem data = addr[3:0]:
  - mem_addr sequence 0,1,2,640,641,642.
  - pix_data 0,1,2,0,1,2.
  - pix_eol on the 3rd and 6th pixels, pix_last on the 6th.
  - done in cycle 9.
- Same window with pix_ready randomly toggled 50%:
  - No lost or duplicated pixels, order preserved.
  - Outputs stable under stall; FIFO never exceeds 2 entries.
- Window (0,0)-(125,125), checksum mode, mem data = addr[3:0]:
  - checksum = 114750 (918 per row).
  - pix_valid never asserted; done in cycle 15627.
- Single pixel (639,479)-(640,480), stream mode: mem_addr = 307199, pix_eol = pix_last = 1.
- Invalid windows: x_end=641 or x_end=x_start → done and err in cycle 1, mem_rd_en never asserted.
- Boundary cases:
  - start pulsed mid-scan is ignored.
  - rst_n low for one cycle mid-scan → all outputs 0 the next cycle, and a new start then scans correctly from scratch.
